// File: rtl/crc_frame_sched_if.sv
// Bundle of the two framer byte streams, the FCS result port and the engine I/O bus.
// master = scheduler side, slave = framers plus engine side.
interface crc_frame_sched_if;
    logic        ch0_valid;
    logic [7:0]  ch0_data;
    logic        ch0_last;
    logic        ch0_mode;
    logic        ch0_ready;
    logic        ch1_valid;
    logic [7:0]  ch1_data;
    logic        ch1_last;
    logic        ch1_mode;
    logic        ch1_ready;
    logic        fcs_valid;
    logic        fcs_ch;
    logic [31:0] fcs;
    logic        busy;
    logic        iocs;
    logic [2:0]  ioaddr;
    logic        iowr;
    logic        iord;
    logic [15:0] iodout;
    logic [15:0] iodin;

    modport master (
        input  ch0_valid, ch0_data, ch0_last, ch0_mode,
        input  ch1_valid, ch1_data, ch1_last, ch1_mode,
        input  iodin,
        output ch0_ready, ch1_ready, fcs_valid, fcs_ch, fcs, busy,
        output iocs, ioaddr, iowr, iord, iodout
    );

    modport slave (
        output ch0_valid, ch0_data, ch0_last, ch0_mode,
        output ch1_valid, ch1_data, ch1_last, ch1_mode,
        output iodin,
        input  ch0_ready, ch1_ready, fcs_valid, fcs_ch, fcs, busy,
        input  iocs, ioaddr, iowr, iord, iodout
    );
endinterface

// File: rtl/crc_frame_sched.sv
// Grants one shared CRC-16/CRC-32 engine to one of two framers per frame and sequences its I/O bus.
// One byte per BYTE_GAP+2 cycles at best; the waiting channel sees ready=0 until the owning frame's DONE.
module crc_frame_sched #(
    parameter int BYTE_GAP = 4,
    parameter int INIT_GAP = 2,
    parameter int RD_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    crc_frame_sched_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_IGAP, S_DATA, S_WR, S_BGAP,
        S_RD_LO, S_RLW, S_RD_HI, S_RHW, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        owner, owner_nxt;
    logic        mode, mode_nxt;
    logic        last_q, last_nxt;
    logic        last_grant, last_grant_nxt;
    logic [15:0] acc_lo, acc_lo_nxt;
    logic [31:0] fcs_q, fcs_nxt;
    logic        fcs_ch_q, fcs_ch_nxt;
    logic        fcs_valid_q, fcs_valid_nxt;
    logic        iocs_q, iocs_nxt, iowr_q, iowr_nxt, iord_q, iord_nxt;
    logic [2:0]  ioaddr_q, ioaddr_nxt;
    logic [15:0] iodout_q, iodout_nxt;
    logic        sel_valid, sel_last;
    logic [7:0]  sel_data;

    assign sel_valid = owner ? bus.ch1_valid : bus.ch0_valid;
    assign sel_data  = owner ? bus.ch1_data  : bus.ch0_data;
    assign sel_last  = owner ? bus.ch1_last  : bus.ch0_last;

    assign bus.ch0_ready = (state == S_DATA) && !owner;
    assign bus.ch1_ready = (state == S_DATA) &&  owner;
    assign bus.busy      = (state != S_IDLE);
    assign bus.fcs_valid = fcs_valid_q;
    assign bus.fcs_ch    = fcs_ch_q;
    assign bus.fcs       = fcs_q;
    assign bus.iocs      = iocs_q;
    assign bus.ioaddr    = ioaddr_q;
    assign bus.iowr      = iowr_q;
    assign bus.iord      = iord_q;
    assign bus.iodout    = iodout_q;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        owner_nxt      = owner;
        mode_nxt       = mode;
        last_nxt       = last_q;
        last_grant_nxt = last_grant;
        acc_lo_nxt     = acc_lo;
        fcs_nxt        = fcs_q;
        fcs_ch_nxt     = fcs_ch_q;

        unique case (state)
            S_IDLE: begin
                // On a tie the channel that did not win last time is served.
                if (bus.ch0_valid && (!bus.ch1_valid || last_grant)) begin
                    owner_nxt = 1'b0; mode_nxt = bus.ch0_mode;
                    last_grant_nxt = 1'b0; state_nxt = S_INIT;
                end else if (bus.ch1_valid) begin
                    owner_nxt = 1'b1; mode_nxt = bus.ch1_mode;
                    last_grant_nxt = 1'b1; state_nxt = S_INIT;
                end
            end
            S_INIT: begin cnt_nxt = '0; state_nxt = S_IGAP; end
            S_IGAP: begin
                if (cnt == 8'(INIT_GAP - 1)) state_nxt = S_DATA;
                else cnt_nxt = cnt + 8'd1;
            end
            S_DATA: begin
                if (sel_valid) begin last_nxt = sel_last; state_nxt = S_WR; end
            end
            S_WR: begin cnt_nxt = '0; state_nxt = S_BGAP; end
            S_BGAP: begin
                if (cnt == 8'(BYTE_GAP - 1)) state_nxt = last_q ? S_RD_LO : S_DATA;
                else cnt_nxt = cnt + 8'd1;
            end
            S_RD_LO: begin cnt_nxt = '0; state_nxt = S_RLW; end
            S_RLW: begin
                if (cnt == 8'(RD_LAT - 1)) begin
                    if (mode) begin
                        acc_lo_nxt = bus.iodin;
                        state_nxt  = S_RD_HI;
                    end else begin
                        fcs_nxt    = {16'h0000, bus.iodin};
                        fcs_ch_nxt = owner;
                        state_nxt  = S_DONE;
                    end
                end else cnt_nxt = cnt + 8'd1;
            end
            S_RD_HI: begin cnt_nxt = '0; state_nxt = S_RHW; end
            S_RHW: begin
                if (cnt == 8'(RD_LAT - 1)) begin
                    fcs_nxt    = {bus.iodin, acc_lo};
                    fcs_ch_nxt = owner;
                    state_nxt  = S_DONE;
                end else cnt_nxt = cnt + 8'd1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Bus strobes are registered from the state being entered, so they last one cycle.
        iocs_nxt      = 1'b0;
        iowr_nxt      = 1'b0;
        iord_nxt      = 1'b0;
        ioaddr_nxt    = 3'd0;
        iodout_nxt    = 16'h0000;
        fcs_valid_nxt = 1'b0;
        case (state_nxt)
            S_INIT:  begin iocs_nxt = 1'b1; iowr_nxt = 1'b1; ioaddr_nxt = 3'd3; iodout_nxt = {15'h0000, mode_nxt}; end
            S_WR:    begin iocs_nxt = 1'b1; iowr_nxt = 1'b1; iodout_nxt = {8'h00, sel_data}; end
            S_RD_LO: begin iocs_nxt = 1'b1; iord_nxt = 1'b1; end
            S_RD_HI: begin iocs_nxt = 1'b1; iord_nxt = 1'b1; ioaddr_nxt = 3'd1; end
            S_DONE:  fcs_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            owner       <= 1'b0;
            mode        <= 1'b0;
            last_q      <= 1'b0;
            last_grant  <= 1'b1;
            acc_lo      <= '0;
            fcs_q       <= '0;
            fcs_ch_q    <= 1'b0;
            fcs_valid_q <= 1'b0;
            iocs_q      <= 1'b0;
            iowr_q      <= 1'b0;
            iord_q      <= 1'b0;
            ioaddr_q    <= '0;
            iodout_q    <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            owner       <= owner_nxt;
            mode        <= mode_nxt;
            last_q      <= last_nxt;
            last_grant  <= last_grant_nxt;
            acc_lo      <= acc_lo_nxt;
            fcs_q       <= fcs_nxt;
            fcs_ch_q    <= fcs_ch_nxt;
            fcs_valid_q <= fcs_valid_nxt;
            iocs_q      <= iocs_nxt;
            iowr_q      <= iowr_nxt;
            iord_q      <= iord_nxt;
            ioaddr_q    <= ioaddr_nxt;
            iodout_q    <= iodout_nxt;
        end
    end
endmodule
